// File: rtl/adder_pkg.sv
// Shared constants and types for the 16-bit ripple adder.
// Contents:
//   ADDER_WIDTH   operand/sum width (16)
//   ADDER_GROUP   bits per carry group (4)
//   adder_word_t  16-bit operand word
//   signed_ovf()  two's-complement overflow from the operand and sum sign bits
package adder_pkg;

  localparam int unsigned ADDER_WIDTH = 16;
  localparam int unsigned ADDER_GROUP = 4;

  typedef logic [ADDER_WIDTH-1:0] adder_word_t;

  // Overflow occurs when both operands share a sign and the sum's sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_4bit.sv
// Purely combinational 4-bit ripple-carry group built from four full-adder bit cells.
// Ports:
//   a, b  [3:0] operand slices
//   cin         carry into bit 0 of the group
//   s     [3:0] sum slice
//   cout        carry out of bit 3 of the group
module adder_4bit
  import adder_pkg::*;
(
  input  logic [ADDER_GROUP-1:0] a,
  input  logic [ADDER_GROUP-1:0] b,
  input  logic                   cin,
  output logic [ADDER_GROUP-1:0] s,
  output logic                   cout
);

  logic [ADDER_GROUP:0] c;

  // Full-adder cells rippled LSB to MSB.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(ADDER_GROUP); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[ADDER_GROUP];
  end

endmodule

// File: rtl/adder_16bit.sv
// Registered 16-bit adder: {cout, s} = a + b + cin, one cycle of latency,
// one new operand set per cycle. Carry ripples through four adder_4bit groups.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (clears s, cout, ovf)
//   a, b  16-bit unsigned operands
//   cin   carry into bit 0
//   s     registered 16-bit sum (modulo 2^16)
//   cout  registered carry out of bit 15
//   ovf   registered signed overflow (only when ADDER_16BIT_OVF_EN is defined)
// Build option: define ADDER_16BIT_OVF_EN to add the ovf port and its register.
module adder_16bit
  import adder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  adder_word_t a,
  input  adder_word_t b,
  input  logic        cin,
  output adder_word_t s,
  output logic        cout
`ifdef ADDER_16BIT_OVF_EN
  ,
  output logic        ovf
`endif
);

  adder_word_t s_next;
  // Inter-group carries kept as separate nets so the chain is a plain DAG.
  logic c1;
  logic c2;
  logic c3;
  logic c4;

  adder_4bit u_grp0 (
    .a    (a[3:0]),
    .b    (b[3:0]),
    .cin  (cin),
    .s    (s_next[3:0]),
    .cout (c1)
  );

  adder_4bit u_grp1 (
    .a    (a[7:4]),
    .b    (b[7:4]),
    .cin  (c1),
    .s    (s_next[7:4]),
    .cout (c2)
  );

  adder_4bit u_grp2 (
    .a    (a[11:8]),
    .b    (b[11:8]),
    .cin  (c2),
    .s    (s_next[11:8]),
    .cout (c3)
  );

  adder_4bit u_grp3 (
    .a    (a[15:12]),
    .b    (b[15:12]),
    .cin  (c3),
    .s    (s_next[15:12]),
    .cout (c4)
  );

  // Output register; reset clears immediately and drops any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= s_next;
      cout <= c4;
    end
  end

`ifdef ADDER_16BIT_OVF_EN
  // Signed overflow registered alongside the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= signed_ovf(a[ADDER_WIDTH-1], b[ADDER_WIDTH-1], s_next[ADDER_WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_adder_16bit.sv
// Self-checking bench for adder_16bit: directed cases plus randomized stream,
// checked every cycle against an arithmetic reference model.
module tb_adder_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a   = '0;
  logic [15:0] b   = '0;
  logic        cin = 1'b0;
  logic [15:0] s;
  logic        cout;
`ifdef ADDER_16BIT_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  adder_16bit dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s),
    .cout (cout)
`ifdef ADDER_16BIT_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: pending result from the inputs held before the edge,
  // published at the edge, cleared by reset.
  logic [16:0] pend_sum = '0;
  logic        pend_ovf = 1'b0;
  logic [16:0] exp_sum  = '0;
  logic        exp_ovf  = 1'b0;
  bit          cmp_en   = 1'b0;

  function automatic logic [16:0] ref_sum(input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
    return 17'(x) + 17'(y) + 17'(c);
  endfunction

  function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y,
                                   input logic c);
    int t;
    t = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (t > 32767) || (t < -32768);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_sum = '0;
      exp_ovf = 1'b0;
    end else begin
      exp_sum = pend_sum;
      exp_ovf = pend_ovf;
    end
  end

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Every-cycle compare on the falling edge, then capture the next pending result.
  always @(negedge clk) begin
    if (cmp_en) begin
      check1("cyc_s", 32'(s), rst ? 32'h0 : 32'(exp_sum[15:0]));
      check1("cyc_cout", 32'(cout), rst ? 32'h0 : 32'(exp_sum[16]));
      check1("cyc_noX", 32'($isunknown({s, cout})), 32'h0);
`ifdef ADDER_16BIT_OVF_EN
      check1("cyc_ovf", 32'(ovf), rst ? 32'h0 : 32'(exp_ovf));
`endif
    end
    pend_sum = ref_sum(a, b, cin);
    pend_ovf = ref_ovf(a, b, cin);
  end

  // Apply one operand set, wait one edge, check DUT and model against a literal.
  task automatic apply(input string name, input logic [15:0] x, input logic [15:0] y,
                       input logic c, input logic [15:0] xs, input logic xc);
    a = x; b = y; cin = c;
    @(posedge clk);
    #1;
    check1({name, "_s"}, 32'(s), 32'(xs));
    check1({name, "_cout"}, 32'(cout), 32'(xc));
    check1({name, "_model"}, 32'(exp_sum), 32'({xc, xs}));
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check1("rst_s", 32'(s), 32'h0);
    check1("rst_cout", 32'(cout), 32'h0);
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    apply("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

    for (int i = 0; i < 16; i++) begin
      apply("walk_a", 16'(1 << i), 16'h0000, 1'b0, 16'(1 << i), 1'b0);
      apply("walk_b", 16'h0000, 16'(1 << i), 1'b0, 16'(1 << i), 1'b0);
    end
    apply("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);

    apply("link0", 16'h0008, 16'h0008, 1'b0, 16'h0010, 1'b0);
    apply("link1", 16'h0080, 16'h0080, 1'b0, 16'h0100, 1'b0);
    apply("link2", 16'h0800, 16'h0800, 1'b0, 16'h1000, 1'b0);
    apply("link3", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    apply("mixed", 16'h1234, 16'hABCD, 1'b1, 16'hBE02, 1'b0);

    apply("cp_pre", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    apply("cp", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

`ifdef ADDER_16BIT_OVF_EN
    apply("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    check1("ovf_pos_ovf", 32'(ovf), 32'h1);
    check1("ovf_pos_model", 32'(exp_ovf), 32'h1);
    apply("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    check1("ovf_neg_ovf", 32'(ovf), 32'h1);
    apply("ovf_none", 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    check1("ovf_none_ovf", 32'(ovf), 32'h0);
`endif

    // Randomized back-to-back stream; the every-cycle compare does the checking.
    for (int n = 0; n < 300; n++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      @(posedge clk); #1;
    end

    // Mid-stream reset: load a known nonzero result, then clear between edges.
    apply("pre_rst", 16'hF000, 16'h1234, 1'b0, 16'h0234, 1'b1);
    a = 16'h4321; b = 16'h1111; cin = 1'b1;
    rst = 1'b1;
    #1;
    check1("async_s", 32'(s), 32'h0);
    check1("async_cout", 32'(cout), 32'h0);
    @(posedge clk); #1;
    check1("hold_s", 32'(s), 32'h0);
    rst = 1'b0;
    apply("post_rst", 16'h4321, 16'h1111, 1'b1, 16'h5433, 1'b0);

    for (int n = 0; n < 100; n++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      if (n == 50) rst = 1'b1;
      if (n == 52) rst = 1'b0;
      @(posedge clk); #1;
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_16bit.md
# adder_16bit

Registered 16-bit binary adder: sums two 16-bit operands plus a carry-in and presents the 16-bit sum and carry-out on registered outputs one clock later. The carry chain is a ripple through four 4-bit adder groups. It is a leaf arithmetic block used wherever a datapath needs a single-cycle, carry-chained add.

## Interface
- WIDTH, 16, operand/sum width; fixed at 16 (localparam, not overridable).
- GROUP, 4, bits per carry group; fixed at 4.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  16  operand A, unsigned.
- b  input  16  operand B, unsigned.
- cin  input  1  carry into bit 0.
- s  output  16  registered sum, a + b + cin, modulo 2^16.
- cout  output  1  registered carry out of bit 15.
- ovf  output  1  registered signed overflow; present only with ADDER_16BIT_OVF_EN.

## Operation
- Combinational sum: {cout, s} = a + b + cin, computed as a 17-bit result with no truncation before the carry is taken.
- The carry chain is built from four adder_4bit instances, each covering bits [4k+3:4k] for k = 0 to 3.
  - Group 0 carry-in is cin.
  - Each group's carry-out drives the next group's carry-in.
  - Group 3 carry-out is cout.
- Operands are unsigned. There is no saturation. Wrap-around is the required behaviour (0xFFFF + 0x0000 + 1 gives s = 0x0000, cout = 1).
- No X propagation: every bit of s and cout is driven from a defined source for all defined inputs.
- No handshake. A new operand set is accepted every cycle.

## Timing
- a, b and cin are sampled on every rising edge of clk. s and cout reflect that sample after the edge: latency 1 cycle, throughput 1 per cycle.
- While rst = 1: s = 0x0000, cout = 0 (and ovf = 0), asynchronously and independently of clk.
- On reset deassertion: the first rising edge with rst = 0 loads the sum of the inputs present at that edge.
- Reset asserted mid-stream: outputs clear immediately, and the in-flight result is discarded.
- Critical path: cin to cout through all 16 bit positions. It must close within one clk period at the target frequency.

## Configuration
- ADDER_16BIT_OVF_EN
  - Defined: port ovf exists and is registered alongside s. Its value is ovf = (a[15] == b[15]) && (s_next[15] != a[15]), i.e. two's-complement signed overflow. It is reset to 0.
  - Undefined: no ovf port and no associated logic. All other behaviour is identical.

## Structure
- Shared package adder_pkg holds the constants ADDER_WIDTH = 16 and ADDER_GROUP = 4, plus a typedef for the 16-bit operand word.
- Sub-module adder_4bit:
  - Ports: a[3:0], b[3:0], cin, s[3:0], cout.
  - Purely combinational ripple of four full-adder bit cells (s = a^b^c, carry = ab | c(a^b)).
- The top level contains:
  - four adder_4bit instances chained by carries;
  - the output register with asynchronous reset;
  - the optional overflow logic.

## Test plan
- Reset and zero: hold rst = 1 and check s = 0x0000, cout = 0. Release, apply a = b = 0, cin = 0, and check s = 0x0000, cout = 0 one cycle later, with no X on any bit.
- Bit-walk connectivity: for each i in 0..15, apply a = 1<<i, b = 0, then a = 0, b = 1<<i, and check s = 1<<i, cout = 0. Also apply cin = 1 alone and check s = 0x0001.
- Group carry links: 0x0008+0x0008 → 0x0010; 0x0080+0x0080 → 0x0100; 0x0800+0x0800 → 0x1000; 0x8000+0x8000 → s = 0x0000, cout = 1. Any ovf check requires ADDER_16BIT_OVF_EN.
- Critical path: apply 0x0000+0x0000, cin = 0, then 0xFFFF+0x0000, cin = 1, and check s = 0x0000, cout = 1 on the next cycle.
- Back-to-back throughput and reset mid-stream:
  - Random operands every cycle: each output equals the 17-bit reference sum delayed by one cycle.
  - Assert rst between edges: outputs go to 0 at once, before the next edge.
- With ADDER_16BIT_OVF_EN: 0x7FFF+0x0001 → s = 0x8000, ovf = 1, cout = 0; 0x8000+0x8000 → ovf = 1; 0x0001+0xFFFF → ovf = 0, cout = 1.
